// File: rtl/ripple_adder_arbiter_if.sv
// rtl/ripple_adder_arbiter_if.sv - request/response bundle for ripple_adder_arbiter
//
// Ports (signals carried by the interface):
//   req0_valid/req0_ready/req0_x/req0_y/req0_sel  requester 0 handshake and operands
//   req1_valid/req1_ready/req1_x/req1_y/req1_sel  requester 1 handshake and operands
//   rsp_valid/rsp_ready/rsp_id/rsp_sum/rsp_cout/rsp_overflow  shared response port
//   busy                                          arbiter is executing or presenting a result
// Modports: slave = arbiter side, master = requesters plus response consumer.

interface ripple_adder_arbiter_if;
    logic       req0_valid;
    logic       req0_ready;
    logic [5:0] req0_x;
    logic [5:0] req0_y;
    logic       req0_sel;
    logic       req1_valid;
    logic       req1_ready;
    logic [5:0] req1_x;
    logic [5:0] req1_y;
    logic       req1_sel;
    logic       rsp_valid;
    logic       rsp_ready;
    logic       rsp_id;
    logic [5:0] rsp_sum;
    logic       rsp_cout;
    logic       rsp_overflow;
    logic       busy;

    modport slave (
        input  req0_valid, req0_x, req0_y, req0_sel,
        input  req1_valid, req1_x, req1_y, req1_sel,
        input  rsp_ready,
        output req0_ready, req1_ready,
        output rsp_valid, rsp_id, rsp_sum, rsp_cout, rsp_overflow, busy
    );

    modport master (
        output req0_valid, req0_x, req0_y, req0_sel,
        output req1_valid, req1_x, req1_y, req1_sel,
        output rsp_ready,
        input  req0_ready, req1_ready,
        input  rsp_valid, rsp_id, rsp_sum, rsp_cout, rsp_overflow, busy
    );
endinterface

// File: rtl/ripple_adder_arbiter.sv
// rtl/ripple_adder_arbiter.sv - round-robin shared six-bit ripple adder/subtractor
//
// six_bit_ripple_adder ports:
//   x_i, y_i  6-bit operands; sel_i 0 = add, 1 = subtract
//   sum_o     6-bit result; cout_o carry out of bit 5; ovf_o signed overflow
// ripple_adder_arbiter ports:
//   clk    rising-edge clock
//   reset  asynchronous active-high reset
//   bus    ripple_adder_arbiter_if.slave: two request ports, one response port, busy

module six_bit_ripple_adder (
    input  logic [5:0] x_i,
    input  logic [5:0] y_i,
    input  logic       sel_i,
    output logic [5:0] sum_o,
    output logic       cout_o,
    output logic       ovf_o
);
    logic [6:0] carry;
    logic [5:0] y_inv;

    // Subtraction is x + ~y + 1: invert y and inject sel as the carry-in.
    assign y_inv    = y_i ^ {6{sel_i}};
    assign carry[0] = sel_i;

    for (genvar i = 0; i < 6; i++) begin : g_bit
        assign sum_o[i]   = x_i[i] ^ y_inv[i] ^ carry[i];
        assign carry[i+1] = (x_i[i] & y_inv[i]) | (carry[i] & (x_i[i] ^ y_inv[i]));
    end

    assign cout_o = carry[6];
    assign ovf_o  = carry[5] ^ carry[6];
endmodule

module ripple_adder_arbiter #(
    parameter int SETTLE_CYCLES = 1,
    parameter int PRIORITY_INIT = 0
) (
    input  logic                          clk,
    input  logic                          reset,
    ripple_adder_arbiter_if.slave         bus
);
    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

    localparam logic [3:0] CNT_INIT = 4'(SETTLE_CYCLES - 1);
    // rr_last names the requester that lost priority, so the favoured one is its complement.
    localparam logic       RR_INIT  = (PRIORITY_INIT == 0) ? 1'b1 : 1'b0;

    state_t     state_q, state_d;
    logic       rr_last_q, rr_last_d;
    logic [5:0] x_q, x_d;
    logic [5:0] y_q, y_d;
    logic       sel_q, sel_d;
    logic       id_q, id_d;
    logic [3:0] cnt_q, cnt_d;
    logic       rsp_valid_q, rsp_valid_d;
    logic       rsp_id_q, rsp_id_d;
    logic [5:0] rsp_sum_q, rsp_sum_d;
    logic       rsp_cout_q, rsp_cout_d;
    logic       rsp_ovf_q, rsp_ovf_d;
    logic       gnt0, gnt1;

    logic [5:0] add_sum;
    logic       add_cout;
    logic       add_ovf;

    // Fed only from the operand registers so port changes cannot disturb an op in flight.
    six_bit_ripple_adder u_adder (
        .x_i    (x_q),
        .y_i    (y_q),
        .sel_i  (sel_q),
        .sum_o  (add_sum),
        .cout_o (add_cout),
        .ovf_o  (add_ovf)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            rr_last_q   <= RR_INIT;
            x_q         <= '0;
            y_q         <= '0;
            sel_q       <= 1'b0;
            id_q        <= 1'b0;
            cnt_q       <= '0;
            rsp_valid_q <= 1'b0;
            rsp_id_q    <= 1'b0;
            rsp_sum_q   <= '0;
            rsp_cout_q  <= 1'b0;
            rsp_ovf_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            rr_last_q   <= rr_last_d;
            x_q         <= x_d;
            y_q         <= y_d;
            sel_q       <= sel_d;
            id_q        <= id_d;
            cnt_q       <= cnt_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_id_q    <= rsp_id_d;
            rsp_sum_q   <= rsp_sum_d;
            rsp_cout_q  <= rsp_cout_d;
            rsp_ovf_q   <= rsp_ovf_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        rr_last_d   = rr_last_q;
        x_d         = x_q;
        y_d         = y_q;
        sel_d       = sel_q;
        id_d        = id_q;
        cnt_d       = cnt_q;
        rsp_valid_d = rsp_valid_q;
        rsp_id_d    = rsp_id_q;
        rsp_sum_d   = rsp_sum_q;
        rsp_cout_d  = rsp_cout_q;
        rsp_ovf_d   = rsp_ovf_q;
        gnt0        = 1'b0;
        gnt1        = 1'b0;

        case (state_q)
            IDLE: begin
                // Under contention the requester that did not win last time is served.
                gnt0 = bus.req0_valid & (~bus.req1_valid | rr_last_q);
                gnt1 = bus.req1_valid & (~bus.req0_valid | ~rr_last_q);
                if (gnt0 | gnt1) begin
                    x_d       = gnt1 ? bus.req1_x   : bus.req0_x;
                    y_d       = gnt1 ? bus.req1_y   : bus.req0_y;
                    sel_d     = gnt1 ? bus.req1_sel : bus.req0_sel;
                    id_d      = gnt1;
                    rr_last_d = gnt1;
                    cnt_d     = CNT_INIT;
                    state_d   = EXEC;
                end
            end
            EXEC: begin
                if (cnt_q != 4'd0) begin
                    cnt_d = cnt_q - 4'd1;
                end else begin
                    rsp_sum_d   = add_sum;
                    rsp_cout_d  = add_cout;
                    rsp_ovf_d   = add_ovf;
                    rsp_id_d    = id_q;
                    rsp_valid_d = 1'b1;
                    state_d     = RESP;
                end
            end
            RESP: begin
                if (rsp_valid_q & bus.rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign bus.req0_ready   = gnt0;
    assign bus.req1_ready   = gnt1;
    assign bus.rsp_valid    = rsp_valid_q;
    assign bus.rsp_id       = rsp_id_q;
    assign bus.rsp_sum      = rsp_sum_q;
    assign bus.rsp_cout     = rsp_cout_q;
    assign bus.rsp_overflow = rsp_ovf_q;
    assign bus.busy         = (state_q != IDLE);
endmodule

// File: tb/tb_ripple_adder_arbiter.sv
// tb/tb_ripple_adder_arbiter.sv - directed self-checking bench for ripple_adder_arbiter

module tb_ripple_adder_arbiter;
    logic clk;
    logic reset;
    int   vectors;
    int   miscompares;

    ripple_adder_arbiter_if rif ();

    ripple_adder_arbiter #(
        .SETTLE_CYCLES (1),
        .PRIORITY_INIT (0)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (rif.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic drive_req(input logic id, input logic v, input logic [5:0] x,
                             input logic [5:0] y, input logic sel);
        if (id == 1'b0) begin
            rif.req0_valid = v; rif.req0_x = x; rif.req0_y = y; rif.req0_sel = sel;
        end else begin
            rif.req1_valid = v; rif.req1_x = x; rif.req1_y = y; rif.req1_sel = sel;
        end
    endtask

    // Called at a negedge; returns at a negedge with the response consumed.
    task automatic do_op(input logic id, input logic [5:0] x, input logic [5:0] y,
                         input logic sel, input logic [5:0] es, input logic ec,
                         input logic eo, input logic hold_rsp);
        int   n;
        logic rdy;
        drive_req(id, 1'b1, x, y, sel);
        rif.rsp_ready = ~hold_rsp;
        #1;
        n = 0;
        rdy = id ? rif.req1_ready : rif.req0_ready;
        while (rdy !== 1'b1 && n < 20) begin
            @(negedge clk); #1; n++;
            rdy = id ? rif.req1_ready : rif.req0_ready;
        end
        chk("grant", {31'd0, rdy}, 32'd1);
        @(posedge clk); #1;
        // Scramble port operands after accept; the op in flight must not see them.
        drive_req(id, 1'b0, ~x, ~y, ~sel);
        @(negedge clk);
        chk("rsp_valid_accept_edge", {31'd0, rif.rsp_valid}, 32'd0);
        chk("busy_exec", {31'd0, rif.busy}, 32'd1);
        @(negedge clk);
        chk("rsp_valid_latency", {31'd0, rif.rsp_valid}, 32'd1);
        chk("rsp_sum", {26'd0, rif.rsp_sum}, {26'd0, es});
        chk("rsp_cout", {31'd0, rif.rsp_cout}, {31'd0, ec});
        chk("rsp_overflow", {31'd0, rif.rsp_overflow}, {31'd0, eo});
        chk("rsp_id", {31'd0, rif.rsp_id}, {31'd0, id});
        if (!hold_rsp) begin
            @(negedge clk);
            chk("rsp_valid_consumed", {31'd0, rif.rsp_valid}, 32'd0);
        end
    endtask

    initial begin
        logic gnt [4];
        int   g;
        vectors = 0;
        miscompares = 0;
        reset = 1'b1;
        rif.rsp_ready = 1'b0;
        drive_req(1'b0, 1'b0, 6'd0, 6'd0, 1'b0);
        drive_req(1'b1, 1'b0, 6'd0, 6'd0, 1'b0);
        @(negedge clk);
        @(negedge clk);

        // Reset state
        chk("reset_rsp_valid", {31'd0, rif.rsp_valid}, 32'd0);
        chk("reset_rsp_sum", {26'd0, rif.rsp_sum}, 32'd0);
        chk("reset_rsp_id", {31'd0, rif.rsp_id}, 32'd0);
        chk("reset_rsp_cout", {31'd0, rif.rsp_cout}, 32'd0);
        chk("reset_rsp_ovf", {31'd0, rif.rsp_overflow}, 32'd0);
        chk("reset_busy", {31'd0, rif.busy}, 32'd0);

        // Both requesters valid from reset: grants must alternate starting with 0
        drive_req(1'b0, 1'b1, 6'd1, 6'd2, 1'b0);
        drive_req(1'b1, 1'b1, 6'd10, 6'd3, 1'b1);
        rif.rsp_ready = 1'b1;
        reset = 1'b0;
        g = 0;
        for (int c = 0; c < 60 && g < 4; c++) begin
            #1;
            chk("readys_exclusive", {31'd0, rif.req0_ready & rif.req1_ready}, 32'd0);
            if (rif.req0_ready | rif.req1_ready) begin
                gnt[g] = rif.req1_ready;
                g++;
            end
            @(negedge clk);
        end
        chk("grant_count", g, 32'd4);
        chk("grant_order_0", {31'd0, gnt[0]}, 32'd0);
        chk("grant_order_1", {31'd0, gnt[1]}, 32'd1);
        chk("grant_order_2", {31'd0, gnt[2]}, 32'd0);
        chk("grant_order_3", {31'd0, gnt[3]}, 32'd1);
        drive_req(1'b0, 1'b0, 6'd0, 6'd0, 1'b0);
        drive_req(1'b1, 1'b0, 6'd0, 6'd0, 1'b0);
        repeat (4) @(negedge clk);
        chk("drain_idle", {31'd0, rif.busy}, 32'd0);

        // Arithmetic vectors
        do_op(1'b0, 6'd5,  6'd3, 1'b0, 6'd8,  1'b0, 1'b0, 1'b0);
        do_op(1'b1, 6'd5,  6'd3, 1'b1, 6'd2,  1'b1, 1'b0, 1'b0);
        do_op(1'b1, 6'd0,  6'd1, 1'b1, 6'd63, 1'b0, 1'b0, 1'b0);
        do_op(1'b0, 6'd31, 6'd1, 1'b0, 6'd32, 1'b0, 1'b1, 1'b0);
        do_op(1'b1, 6'd32, 6'd1, 1'b1, 6'd31, 1'b1, 1'b1, 1'b0);

        // Response held for 10 cycles while the ports churn
        do_op(1'b0, 6'd7, 6'd9, 1'b0, 6'd16, 1'b0, 1'b0, 1'b1);
        for (int c = 0; c < 10; c++) begin
            drive_req(1'b0, 1'b1, 6'($urandom_range(0, 63)), 6'($urandom_range(0, 63)), 1'b1);
            drive_req(1'b1, 1'b1, 6'($urandom_range(0, 63)), 6'($urandom_range(0, 63)), 1'b0);
            #1;
            chk("hold_rsp_valid", {31'd0, rif.rsp_valid}, 32'd1);
            chk("hold_rsp_sum", {26'd0, rif.rsp_sum}, 32'd16);
            chk("hold_readys_low", {31'd0, rif.req0_ready | rif.req1_ready}, 32'd0);
            @(negedge clk);
        end
        drive_req(1'b0, 1'b0, 6'd0, 6'd0, 1'b0);
        drive_req(1'b1, 1'b0, 6'd0, 6'd0, 1'b0);
        rif.rsp_ready = 1'b1;
        @(negedge clk);
        chk("hold_released", {31'd0, rif.rsp_valid}, 32'd0);

        // Reset during EXEC discards the op
        drive_req(1'b0, 1'b1, 6'd3, 6'd4, 1'b0);
        #1;
        chk("pre_reset_grant", {31'd0, rif.req0_ready}, 32'd1);
        @(posedge clk); #1;
        drive_req(1'b0, 1'b0, 6'd0, 6'd0, 1'b0);
        @(negedge clk);
        chk("pre_reset_busy", {31'd0, rif.busy}, 32'd1);
        reset = 1'b1;
        #1;
        chk("reset_async_valid", {31'd0, rif.rsp_valid}, 32'd0);
        chk("reset_async_busy", {31'd0, rif.busy}, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        chk("post_reset_valid", {31'd0, rif.rsp_valid}, 32'd0);
        chk("post_reset_busy", {31'd0, rif.busy}, 32'd0);
        do_op(1'b0, 6'd1, 6'd1, 1'b0, 6'd2, 1'b0, 1'b0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
